// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage with a circular queue between fetch and dispatch.
// Each instruction is decoded as it is enqueued, so the head entry is already decoded when dispatch sees it.
module decode_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     enq_valid_in,
  output logic                     enq_ready_out,
  input  logic [31:0]              enq_instr_in,
  input  logic [ADDR_W-1:0]        enq_pc_in,
  output logic                     deq_valid_out,
  input  logic                     deq_ready_in,
  output logic [OP_W-1:0]          deq_opcode_out,
  output logic [4:0]               deq_rs1_out,
  output logic [4:0]               deq_rs2_out,
  output logic [4:0]               deq_rd_out,
  output logic [31:0]              deq_imm_out,
  output logic [ADDR_W-1:0]        deq_pc_out,
  output logic                     deq_illegal_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Internal opcode codes (const.v numbering)
  localparam logic [OP_W-1:0] OP_NULL  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LB    = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LH    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LBU   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_LHU   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SB    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SH    = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(18);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] pc;
    logic              illegal;
  } entry_t;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  entry_t           dec_entry;
  logic             enq_fire, deq_fire;

  assign enq_ready_out = (count_q < FULL_CNT);
  assign deq_valid_out = (count_q != '0);
  assign count_out     = count_q;
  assign enq_fire      = enq_valid_in & enq_ready_out & rdy_in;
  assign deq_fire      = deq_valid_out & deq_ready_in & rdy_in;

  assign deq_opcode_out  = entries_q[head_q].opcode;
  assign deq_rs1_out     = entries_q[head_q].rs1;
  assign deq_rs2_out     = entries_q[head_q].rs2;
  assign deq_rd_out      = entries_q[head_q].rd;
  assign deq_imm_out     = entries_q[head_q].imm;
  assign deq_pc_out      = entries_q[head_q].pc;
  assign deq_illegal_out = entries_q[head_q].illegal;

  // Decode the offered instruction; anything unsupported collapses to a zeroed NULL entry flagged illegal
  always_comb begin
    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    ins = enq_instr_in;
    f3  = ins[14:12];
    f7  = ins[31:25];
    dec_entry         = '0;
    dec_entry.pc      = enq_pc_in;
    dec_entry.rs1     = ins[19:15];
    dec_entry.rs2     = ins[24:20];
    dec_entry.rd      = ins[11:7];
    dec_entry.opcode  = OP_NULL;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin
        dec_entry.opcode = (ins[5]) ? OP_LUI : OP_AUIPC;
        dec_entry.rs1    = '0;
        dec_entry.rs2    = '0;
        dec_entry.imm    = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_entry.opcode = OP_JAL;
        dec_entry.rs1    = '0;
        dec_entry.rs2    = '0;
        dec_entry.imm    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111: begin
        dec_entry.opcode = (f3 == 3'b000) ? OP_JALR : OP_NULL;
        dec_entry.rs2    = '0;
        dec_entry.imm    = {{20{ins[31]}}, ins[31:20]};
      end
      7'b1100011: begin
        case (f3)
          3'b000:  dec_entry.opcode = OP_BEQ;
          3'b001:  dec_entry.opcode = OP_BNE;
          3'b100:  dec_entry.opcode = OP_BLT;
          3'b101:  dec_entry.opcode = OP_BGE;
          3'b110:  dec_entry.opcode = OP_BLTU;
          3'b111:  dec_entry.opcode = OP_BGEU;
          default: dec_entry.opcode = OP_NULL;
        endcase
        dec_entry.rd  = '0;
        dec_entry.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0000011: begin
        case (f3)
          3'b000:  dec_entry.opcode = OP_LB;
          3'b001:  dec_entry.opcode = OP_LH;
          3'b010:  dec_entry.opcode = OP_LW;
          3'b100:  dec_entry.opcode = OP_LBU;
          3'b101:  dec_entry.opcode = OP_LHU;
          default: dec_entry.opcode = OP_NULL;
        endcase
        dec_entry.rs2 = '0;
        dec_entry.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        case (f3)
          3'b000:  dec_entry.opcode = OP_SB;
          3'b001:  dec_entry.opcode = OP_SH;
          3'b010:  dec_entry.opcode = OP_SW;
          default: dec_entry.opcode = OP_NULL;
        endcase
        dec_entry.rd  = '0;
        dec_entry.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b0010011: begin
        dec_entry.rs2 = '0;
        dec_entry.imm = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'b000: dec_entry.opcode = OP_ADDI;
          3'b010: dec_entry.opcode = OP_SLTI;
          3'b011: dec_entry.opcode = OP_SLTIU;
          3'b100: dec_entry.opcode = OP_XORI;
          3'b110: dec_entry.opcode = OP_ORI;
          3'b111: dec_entry.opcode = OP_ANDI;
          3'b001: dec_entry.opcode = (f7 == 7'b0000000) ? OP_SLLI : OP_NULL;
          default: begin
            if (f7 == 7'b0000000)      dec_entry.opcode = OP_SRLI;
            else if (f7 == 7'b0100000) dec_entry.opcode = OP_SRAI;
            else                       dec_entry.opcode = OP_NULL;
          end
        endcase
        if (f3 == 3'b001 || f3 == 3'b101) dec_entry.imm = {27'b0, ins[24:20]};
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_entry.opcode = OP_ADD;
            3'b001:  dec_entry.opcode = OP_SLL;
            3'b010:  dec_entry.opcode = OP_SLT;
            3'b011:  dec_entry.opcode = OP_SLTU;
            3'b100:  dec_entry.opcode = OP_XOR;
            3'b101:  dec_entry.opcode = OP_SRL;
            3'b110:  dec_entry.opcode = OP_OR;
            default: dec_entry.opcode = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec_entry.opcode = OP_SUB;
            3'b101:  dec_entry.opcode = OP_SRA;
            default: dec_entry.opcode = OP_NULL;
          endcase
        end
      end
      default: dec_entry.opcode = OP_NULL;
    endcase
    if (dec_entry.opcode == OP_NULL) begin
      dec_entry.illegal = 1'b1;
      dec_entry.rs1     = '0;
      dec_entry.rs2     = '0;
      dec_entry.rd      = '0;
      dec_entry.imm     = '0;
    end
  end

  // Next pointers, count and storage; flush wins over any same-cycle handshake, and rdy_in low freezes everything
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (rdy_in) begin
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (enq_fire) begin
          entries_d[tail_q] = dec_entry;
          tail_d            = tail_q + PTR_W'(1);
        end
        if (deq_fire) head_d = head_q + PTR_W'(1);
        case ({enq_fire, deq_fire})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Pointer and count registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; valid entries are tracked by count alone
  always_ff @(posedge clk_in) begin
    entries_q <= entries_d;
  end

endmodule
